// File: rtl/stein_gcd_pkg.sv
// Shared definitions for the stein_gcd core and its host sequencer.
// Operands are sign-magnitude: bit SIGN_BIT is the sign, MAG_MASK selects the magnitude.
package stein_gcd_pkg;

    localparam int GCD_WIDTH   = 8;
    localparam int GCD_LATENCY = 10;

    localparam int                    SIGN_BIT = GCD_WIDTH - 1;
    localparam logic [GCD_WIDTH-1:0]  MAG_MASK = {1'b0, {(GCD_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } host_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stein_gcd_host.sv
// Request/response sequencer for the stein_gcd core: latches operands, pulses
// core_start, waits a fixed latency, then returns the sampled result.
module stein_gcd_host
    import stein_gcd_pkg::*;
#(
    parameter int WIDTH        = GCD_WIDTH,
    parameter int START_CYCLES = 1,
    parameter int LATENCY      = GCD_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             core_start,
    input  logic [WIDTH-1:0] core_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_a,
    output logic [WIDTH-1:0] rsp_b,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(max_int(START_CYCLES, LATENCY)) + 1;
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
    // The core registers its first step on the edge after core_start drops, so
    // WAIT spans LATENCY+1 cycles and the result is sampled once LATENCY steps are done.
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    host_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_core_a;
    logic [WIDTH-1:0] r_core_b;
    logic             r_core_start;
    logic [WIDTH-1:0] r_rsp_a;
    logic [WIDTH-1:0] r_rsp_b;
    logic [WIDTH-1:0] r_rsp_gcd;
    logic             r_rsp_zero;
    logic             r_rsp_valid;

    logic w_accept;
    logic w_rsp_fire;

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign w_accept   = req_valid & req_ready;
    assign w_rsp_fire = r_rsp_valid & rsp_ready;

    assign core_a     = r_core_a;
    assign core_b     = r_core_b;
    assign core_start = r_core_start;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_a      = r_rsp_a;
    assign rsp_b      = r_rsp_b;
    assign rsp_gcd    = r_rsp_gcd;
    assign rsp_zero   = r_rsp_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_core_a     <= '0;
            r_core_b     <= '0;
            r_core_start <= 1'b0;
            r_rsp_a      <= '0;
            r_rsp_b      <= '0;
            r_rsp_gcd    <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_core_a     <= req_a;
                        r_core_b     <= req_b;
                        r_rsp_a      <= req_a;
                        r_rsp_b      <= req_b;
                        r_cnt        <= START_LOAD;
                        r_core_start <= 1'b1;
                        r_state      <= START;
                    end
                end
                START: begin
                    if (r_cnt == '0) begin
                        r_core_start <= 1'b0;
                        r_cnt        <= WAIT_LOAD;
                        r_state      <= WAIT;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_gcd   <= core_res;
                        r_rsp_zero  <= (core_res == '0);
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_core_start <= 1'b0;
                    r_rsp_valid  <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stein_gcd_host.sv
// Directed bench for stein_gcd_host with a behavioural GCD core model;
// a second instance covers START_CYCLES=3, LATENCY=1.
module tb_stein_gcd_host;
    import stein_gcd_pkg::*;

    localparam int W = GCD_WIDTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         req_valid, req_ready, core_start, rsp_valid, rsp_ready, rsp_zero, busy;
    logic [W-1:0] req_a, req_b, core_a, core_b, core_res, rsp_a, rsp_b, rsp_gcd;

    logic         req_valid2, req_ready2, core_start2, rsp_valid2, rsp_ready2, rsp_zero2, busy2;
    logic [W-1:0] req_a2, req_b2, core_a2, core_b2, core_res2, rsp_a2, rsp_b2, rsp_gcd2;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int starts;

    stein_gcd_host #(.WIDTH(W), .START_CYCLES(1), .LATENCY(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .core_a(core_a), .core_b(core_b), .core_start(core_start), .core_res(core_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_gcd(rsp_gcd), .rsp_zero(rsp_zero), .busy(busy)
    );

    stein_gcd_host #(.WIDTH(W), .START_CYCLES(3), .LATENCY(1)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_a(req_a2), .req_b(req_b2),
        .core_a(core_a2), .core_b(core_b2), .core_start(core_start2), .core_res(core_res2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_a(rsp_a2), .rsp_b(rsp_b2),
        .rsp_gcd(rsp_gcd2), .rsp_zero(rsp_zero2), .busy(busy2)
    );

    // Core model: result forced to 0 while start is high, valid one edge after it drops.
    function automatic logic [W-1:0] gcd_model(input logic [W-1:0] a, input logic [W-1:0] b);
        int x;
        int y;
        int t;
        x = int'(a & MAG_MASK);
        y = int'(b & MAG_MASK);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    always @(posedge clk) begin
        core_res  <= core_start  ? '0 : gcd_model(core_a,  core_b);
        core_res2 <= core_start2 ? '0 : gcd_model(core_a2, core_b2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        check({tag, " req_ready"}, 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts cycles from the accepting edge until rsp_valid, bounded.
    task automatic wait_rsp(output int l, output int s);
        l = 0;
        s = 0;
        while (!rsp_valid && l < 100) begin
            if (core_start) s++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic expect_rsp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] g, input logic z);
        check({tag, " latency"},   32'(lat), 12);
        check({tag, " start_len"}, 32'(starts), 1);
        check({tag, " rsp_gcd"},   32'(rsp_gcd), 32'(g));
        check({tag, " rsp_zero"},  32'(rsp_zero), 32'(z));
        check({tag, " rsp_a"},     32'(rsp_a), 32'(a));
        check({tag, " rsp_b"},     32'(rsp_b), 32'(b));
        check({tag, " core_a"},    32'(core_a), 32'(a));
        $display("[TB] %s a=%02h b=%02h gcd=%02h zero=%0b lat=%0d", tag, rsp_a, rsp_b, rsp_gcd, rsp_zero, lat);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " rsp_valid_clr"}, 32'(rsp_valid), 0);
        check({tag, " busy_clr"},      32'(busy), 0);
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        req_valid2 = 1'b0; req_a2 = '0; req_b2 = '0; rsp_ready2 = 1'b0;
        #1;
        check("rst req_ready",  32'(req_ready), 1);
        check("rst core_start", 32'(core_start), 0);
        check("rst rsp_valid",  32'(rsp_valid), 0);
        check("rst busy",       32'(busy), 0);
        check("rst core_a",     32'(core_a), 0);
        check("rst rsp_gcd",    32'(rsp_gcd), 0);
        check("rst rsp_zero",   32'(rsp_zero), 0);
        check("rst rsp_a",      32'(rsp_a), 0);
        $display("[TB] reset state checked");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic accept
        rsp_ready = 1'b1;
        send(8'h00, 8'h04, "basic");
        wait_rsp(lat, starts);
        expect_rsp("basic", 8'h00, 8'h04, 8'h04, 1'b0);
        finish_rsp("basic");

        // Signed operands
        send(8'hB6, 8'h2D, "signed1");
        wait_rsp(lat, starts);
        expect_rsp("signed1", 8'hB6, 8'h2D, 8'h09, 1'b0);
        finish_rsp("signed1");
        send(8'h3F, 8'h9C, "signed2");
        wait_rsp(lat, starts);
        expect_rsp("signed2", 8'h3F, 8'h9C, 8'h07, 1'b0);
        finish_rsp("signed2");

        // Zero case
        send(8'h00, 8'h00, "zero");
        wait_rsp(lat, starts);
        expect_rsp("zero", 8'h00, 8'h00, 8'h00, 1'b1);
        finish_rsp("zero");

        // Backpressure, with a second request pending
        rsp_ready = 1'b0;
        send(8'h0A, 8'h04, "bp");
        wait_rsp(lat, starts);
        expect_rsp("bp", 8'h0A, 8'h04, 8'h02, 1'b0);
        req_a = 8'h3F; req_b = 8'h9C; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp hold rsp_valid", 32'(rsp_valid), 1);
            check("bp hold rsp_gcd",   32'(rsp_gcd), 32'h02);
            check("bp hold req_ready", 32'(req_ready), 0);
            check("bp hold core_a",    32'(core_a), 32'h0A);
            @(posedge clk); #1;
        end
        $display("[TB] bp held 20 cycles rsp_gcd=%02h", rsp_gcd);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp hs rsp_valid", 32'(rsp_valid), 0);
        check("bp hs busy",      32'(busy), 0);
        check("bp hs req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp2 accepted busy", 32'(busy), 1);
        check("bp2 core_start",    32'(core_start), 1);
        wait_rsp(lat, starts);
        expect_rsp("bp2", 8'h3F, 8'h9C, 8'h07, 1'b0);
        finish_rsp("bp2");

        // Reset during WAIT
        send(8'h04, 8'h09, "midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst pre busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("midrst core_start", 32'(core_start), 0);
        check("midrst rsp_valid",  32'(rsp_valid), 0);
        check("midrst busy",       32'(busy), 0);
        check("midrst core_a",     32'(core_a), 0);
        check("midrst req_ready",  32'(req_ready), 1);
        $display("[TB] midrst reset applied busy=%0b", busy);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send(8'h04, 8'h09, "postrst");
        wait_rsp(lat, starts);
        expect_rsp("postrst", 8'h04, 8'h09, 8'h01, 1'b0);
        finish_rsp("postrst");

        // Parameter sweep instance: START_CYCLES=3, LATENCY=1
        rsp_ready2 = 1'b1;
        req_a2 = 8'h0C; req_b2 = 8'h12; req_valid2 = 1'b1;
        check("sweep req_ready", 32'(req_ready2), 1);
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        lat = 0;
        starts = 0;
        while (!rsp_valid2 && lat < 100) begin
            if (core_start2) starts++;
            @(posedge clk); #1;
            lat++;
        end
        check("sweep start_len", 32'(starts), 3);
        check("sweep latency",   32'(lat), 5);
        check("sweep rsp_gcd",   32'(rsp_gcd2), 32'h06);
        check("sweep rsp_zero",  32'(rsp_zero2), 0);
        $display("[TB] sweep a=%02h b=%02h gcd=%02h start_len=%0d lat=%0d", rsp_a2, rsp_b2, rsp_gcd2, starts, lat);
        @(posedge clk); #1;
        check("sweep rsp_valid_clr", 32'(rsp_valid2), 0);

        // Reset during START drops core_start without a clock edge
        req_valid2 = 1'b1;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        check("startrst pre core_start", 32'(core_start2), 1);
        reset = 1'b0;
        #1;
        check("startrst core_start", 32'(core_start2), 0);
        check("startrst busy",       32'(busy2), 0);
        $display("[TB] startrst core_start=%0b busy=%0b", core_start2, busy2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
